// File: rtl/dbuf_load_sched_if.sv
// Handshake bundle between the data-buffer load scheduler and its neighbours.
// master = layer controller / DDR engine / loader / PE side; slave = scheduler.
interface dbuf_load_sched_if #(
  parameter int DDR_ADDR_W = 32,
  parameter int LEN_W      = 13
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [2:0]            cmd_mode;
  logic [3:0]            cmd_ch_num;
  logic [3:0]            cmd_row_num;
  logic [3:0]            cmd_pix_num;
  logic [DDR_ADDR_W-1:0] cmd_addr;

  logic                  ddr_req_valid;
  logic                  ddr_req_ready;
  logic [DDR_ADDR_W-1:0] ddr_req_addr;
  logic [LEN_W-1:0]      ddr_req_len;

  logic                  ld_start;
  logic                  ld_done;
  logic [2:0]            ld_mode;
  logic [3:0]            ld_ch_num;
  logic [3:0]            ld_row_num;
  logic [3:0]            ld_pix_num;
  logic                  wr_bank;

  logic                  rd_valid;
  logic                  rd_bank;
  logic                  rel_valid;
  logic                  rel_bank;

  modport master (
    output cmd_valid, cmd_mode, cmd_ch_num, cmd_row_num, cmd_pix_num, cmd_addr,
    input  cmd_ready,
    input  ddr_req_valid, ddr_req_addr, ddr_req_len,
    output ddr_req_ready,
    input  ld_start, ld_mode, ld_ch_num, ld_row_num, ld_pix_num, wr_bank,
    output ld_done,
    input  rd_valid, rd_bank,
    output rel_valid, rel_bank
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_ch_num, cmd_row_num, cmd_pix_num, cmd_addr,
    output cmd_ready,
    output ddr_req_valid, ddr_req_addr, ddr_req_len,
    input  ddr_req_ready,
    output ld_start, ld_mode, ld_ch_num, ld_row_num, ld_pix_num, wr_bank,
    input  ld_done,
    output rd_valid, rd_bank,
    input  rel_valid, rel_bank
  );
endinterface

// File: rtl/dbuf_load_sched.sv
// Ping-pong data-buffer load scheduler: one DDR burst + loader run per command.
// Optional perf counters enabled by defining DBUF_LOAD_SCHED_PERF_EN.
module dbuf_load_sched #(
  parameter int DDR_ADDR_W = 32,
  parameter int LEN_W      = 13
) (
  input  logic                   clk,
  input  logic                   rst,
  dbuf_load_sched_if.slave       bus,
  output logic                   idle,
  output logic [31:0]            perf_busy_cyc,
  output logic [15:0]            perf_loads
);

  typedef enum logic [2:0] {
    S_IDLE, S_ALLOC, S_START, S_REQ, S_WAIT, S_COMMIT
  } state_t;

  state_t                state_reg, state_next;
  logic [2:0]            mode_reg;
  logic [3:0]            ch_reg, row_reg, pix_reg;
  logic [DDR_ADDR_W-1:0] addr_reg;
  logic [LEN_W-1:0]      len_reg;
  logic [LEN_W-1:0]      ch_p1, row_p1, pix_p1, len_calc;
  logic                  busy_seen_reg, busy_seen_next;
  logic                  wr_ptr_reg, rd_ptr_reg;
  logic [1:0]            bank_full;
  logic                  accept, commit, rel_ok;

  assign accept = bus.cmd_valid && (state_reg == S_IDLE);
  assign commit = (state_reg == S_COMMIT);
  assign rel_ok = bus.rel_valid && (bus.rel_bank == rd_ptr_reg) && bank_full[rd_ptr_reg];

  // Product of three 1..16 factors peaks at 4096, so LEN_W bits never overflow.
  assign ch_p1    = LEN_W'(ch_reg)  + LEN_W'(1);
  assign row_p1   = LEN_W'(row_reg) + LEN_W'(1);
  assign pix_p1   = LEN_W'(pix_reg) + LEN_W'(1);
  assign len_calc = mode_reg[0] ? ch_p1 : (ch_p1 * row_p1 * pix_p1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      busy_seen_reg <= 1'b0;
      mode_reg      <= '0;
      ch_reg        <= '0;
      row_reg       <= '0;
      pix_reg       <= '0;
      addr_reg      <= '0;
      len_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      busy_seen_reg <= busy_seen_next;
      if (accept) begin
        mode_reg <= bus.cmd_mode;
        ch_reg   <= bus.cmd_ch_num;
        row_reg  <= bus.cmd_row_num;
        pix_reg  <= bus.cmd_pix_num;
        addr_reg <= bus.cmd_addr;
      end
      // Length is formed from the latched fields; ALLOC always lasts at least one cycle.
      if (state_reg == S_ALLOC) begin
        len_reg <= len_calc;
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    busy_seen_next = 1'b0;
    case (state_reg)
      S_IDLE:   if (bus.cmd_valid) state_next = S_ALLOC;
      S_ALLOC:  if (!bank_full[wr_ptr_reg]) state_next = S_START;
      S_START:  state_next = S_REQ;
      S_REQ:    if (bus.ddr_req_ready) state_next = S_WAIT;
      S_WAIT: begin
        // A done seen before the loader has gone busy is left over from the previous run.
        busy_seen_next = busy_seen_reg || !bus.ld_done;
        if (busy_seen_reg && bus.ld_done) state_next = S_COMMIT;
      end
      S_COMMIT: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
    end else begin
      if (commit) wr_ptr_reg <= ~wr_ptr_reg;
      if (rel_ok) rd_ptr_reg <= ~rd_ptr_reg;
    end
  end

  // Commit and release never target the same bank: ALLOC only proceeds onto an empty one.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      logic full_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          full_reg <= 1'b0;
        end else if (commit && (wr_ptr_reg == 1'(gi))) begin
          full_reg <= 1'b1;
        end else if (rel_ok && (rd_ptr_reg == 1'(gi))) begin
          full_reg <= 1'b0;
        end
      end
      assign bank_full[gi] = full_reg;
    end
  endgenerate

  assign bus.cmd_ready     = (state_reg == S_IDLE);
  assign idle              = (state_reg == S_IDLE);
  assign bus.ld_start      = (state_reg == S_START);
  assign bus.ddr_req_valid = (state_reg == S_REQ);
  assign bus.ddr_req_addr  = addr_reg;
  assign bus.ddr_req_len   = len_reg;
  assign bus.ld_mode       = mode_reg;
  assign bus.ld_ch_num     = ch_reg;
  assign bus.ld_row_num    = row_reg;
  assign bus.ld_pix_num    = pix_reg;
  assign bus.wr_bank       = wr_ptr_reg;
  assign bus.rd_bank       = rd_ptr_reg;
  assign bus.rd_valid      = bank_full[rd_ptr_reg];

`ifdef DBUF_LOAD_SCHED_PERF_EN
  logic [31:0] busy_cyc_reg;
  logic [15:0] loads_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_cyc_reg <= '0;
      loads_reg    <= '0;
    end else begin
      if ((state_reg == S_WAIT) && (busy_cyc_reg != '1)) busy_cyc_reg <= busy_cyc_reg + 32'd1;
      if (commit) loads_reg <= loads_reg + 16'd1;
    end
  end

  assign perf_busy_cyc = busy_cyc_reg;
  assign perf_loads    = loads_reg;
`else
  assign perf_busy_cyc = '0;
  assign perf_loads    = '0;
`endif

endmodule

// File: tb/tb_dbuf_load_sched.sv
// Randomised self-checking bench for dbuf_load_sched against a bank/queue level model.
module tb_dbuf_load_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        idle;
  logic [31:0] perf_busy_cyc;
  logic [15:0] perf_loads;

  int checks   = 0;
  int failures = 0;

  // Reference model: per-bank full flags, next bank to fill, oldest bank to read.
  logic [1:0] m_full;
  logic       m_wr, m_rd;
  longint     m_busy;
  int         m_loads;

  always #5 clk = ~clk;

  dbuf_load_sched_if #(.DDR_ADDR_W(32), .LEN_W(13)) bus ();

  dbuf_load_sched #(.DDR_ADDR_W(32), .LEN_W(13)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus.slave),
    .idle          (idle),
    .perf_busy_cyc (perf_busy_cyc),
    .perf_loads    (perf_loads)
  );

  function automatic int exp_len(input logic [2:0] m, input logic [3:0] c, input logic [3:0] r,
                                 input logic [3:0] p);
    if (m[0]) return int'(c) + 1;
    return (int'(c) + 1) * (int'(r) + 1) * (int'(p) + 1);
  endfunction

  function automatic void model_release(input logic b);
    if (b == m_rd && m_full[m_rd]) begin
      m_full[m_rd] = 1'b0;
      m_rd         = ~m_rd;
    end
  endfunction

  function automatic void model_reset();
    m_full  = 2'b00;
    m_wr    = 1'b0;
    m_rd    = 1'b0;
    m_busy  = 0;
    m_loads = 0;
  endfunction

  task automatic abort_run(input string what);
    failures++;
    $display("FAIL timeout_%s waited 50 cycles, event required", what);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  task automatic do_release(input logic b);
    bus.rel_valid = 1'b1;
    bus.rel_bank  = b;
    @(negedge clk);
    bus.rel_valid = 1'b0;
    model_release(b);
    checks++;
    if ({bus.rd_valid, bus.rd_bank, bus.wr_bank} !== {m_full[m_rd], m_rd, m_wr}) begin
      failures++;
      $display("FAIL release(%0d) rd_valid/rd_bank/wr_bank got=%b%b%b exp=%b%b%b", b,
               bus.rd_valid, bus.rd_bank, bus.wr_bank, m_full[m_rd], m_rd, m_wr);
    end
  endtask

  // One complete load; stalls are resolved by releasing the oldest bank.
  task automatic run_load(input logic [2:0] mode, input logic [3:0] ch, input logic [3:0] row,
                          input logic [3:0] pix, input logic [31:0] addr, input int rdy_dly,
                          input int busy, input int stale, input bit rel_at_commit);
    logic [12:0] elen;
    logic [31:0] eb;
    logic [15:0] el;
    int n;
    elen = 13'(exp_len(mode, ch, row, pix));
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin abort_run("cmd_ready"); return; end
    bus.cmd_valid = 1'b1; bus.cmd_mode = mode; bus.cmd_ch_num = ch;
    bus.cmd_row_num = row; bus.cmd_pix_num = pix; bus.cmd_addr = addr;
    @(negedge clk);
    bus.cmd_valid = 1'b0; bus.cmd_mode = 3'($urandom); bus.cmd_ch_num = 4'($urandom);
    bus.cmd_row_num = 4'($urandom); bus.cmd_pix_num = 4'($urandom); bus.cmd_addr = $urandom;
    checks++;
    if ({bus.cmd_ready, idle, bus.ld_start} !== 3'b000) begin
      failures++;
      $display("FAIL after_accept ready/idle/start got=%b%b%b exp=000", bus.cmd_ready, idle, bus.ld_start);
    end
    if (m_full[m_wr]) begin
      repeat (6) begin
        checks++;
        if ({bus.cmd_ready, bus.ld_start, idle, bus.ddr_req_valid} !== 4'b0000) begin
          failures++;
          $display("FAIL alloc_stall ready/start/idle/req got=%b%b%b%b exp=0000",
                   bus.cmd_ready, bus.ld_start, idle, bus.ddr_req_valid);
        end
        @(negedge clk);
      end
      bus.rel_valid = 1'b1; bus.rel_bank = m_rd;
      model_release(m_rd);
      @(negedge clk);
      bus.rel_valid = 1'b0;
    end
    n = 0;
    while (bus.ld_start !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin abort_run("ld_start"); return; end
    checks++;
    if ({bus.ld_mode, bus.ld_ch_num, bus.ld_row_num, bus.ld_pix_num} !== {mode, ch, row, pix}) begin
      failures++;
      $display("FAIL ld_config got=%h_%h_%h_%h exp=%h_%h_%h_%h", bus.ld_mode, bus.ld_ch_num,
               bus.ld_row_num, bus.ld_pix_num, mode, ch, row, pix);
    end
    checks++;
    if ({bus.ddr_req_valid, bus.ddr_req_len, bus.wr_bank} !== {1'b0, elen, m_wr}) begin
      failures++;
      $display("FAIL start_phase req_valid=%b len=%0d wr_bank=%b exp 0 %0d %b",
               bus.ddr_req_valid, bus.ddr_req_len, bus.wr_bank, elen, m_wr);
    end
    if (stale == 0) bus.ld_done = 1'b0;
    @(negedge clk);
    for (int i = 0; i <= rdy_dly; i++) begin
      checks++;
      if ({bus.ddr_req_valid, bus.ddr_req_addr, bus.ddr_req_len, bus.ld_start} !== {1'b1, addr, elen, 1'b0}) begin
        failures++;
        $display("FAIL ddr_req cyc%0d valid=%b addr=%h len=%0d start=%b exp 1 %h %0d 0", i,
                 bus.ddr_req_valid, bus.ddr_req_addr, bus.ddr_req_len, bus.ld_start, addr, elen);
      end
      if (i == rdy_dly) bus.ddr_req_ready = 1'b1;
      @(negedge clk);
    end
    bus.ddr_req_ready = 1'b1;
    for (int i = 0; i < stale + busy; i++) begin
      if (i == 1) bus.ddr_req_ready = 1'b0;
      if (i == stale) bus.ld_done = 1'b0;
      checks++;
      if ({bus.ddr_req_valid, idle, bus.wr_bank, bus.rd_valid, bus.ld_row_num, bus.ld_pix_num} !==
          {1'b0, 1'b0, m_wr, m_full[m_rd], row, pix}) begin
        failures++;
        $display("FAIL wait_phase cyc%0d req=%b idle=%b wr=%b rdv=%b row=%h pix=%h exp 0 0 %b %b %h %h",
                 i, bus.ddr_req_valid, idle, bus.wr_bank, bus.rd_valid, bus.ld_row_num,
                 bus.ld_pix_num, m_wr, m_full[m_rd], row, pix);
      end
      @(negedge clk);
    end
    bus.ddr_req_ready = 1'b0;
    bus.ld_done = 1'b1;
    @(negedge clk);
    checks++;
    if ({idle, bus.cmd_ready, bus.wr_bank} !== {1'b0, 1'b0, m_wr}) begin
      failures++;
      $display("FAIL commit_cycle idle/ready/wr got=%b%b%b exp=00%b", idle, bus.cmd_ready, bus.wr_bank, m_wr);
    end
    if (rel_at_commit) begin bus.rel_valid = 1'b1; bus.rel_bank = m_rd; model_release(m_rd); end
    @(negedge clk);
    bus.rel_valid = 1'b0;
    m_full[m_wr] = 1'b1;
    m_wr         = ~m_wr;
    m_loads++;
    m_busy += stale + busy + 1;
    checks++;
    if ({idle, bus.cmd_ready, bus.rd_valid, bus.rd_bank, bus.wr_bank} !==
        {1'b1, 1'b1, m_full[m_rd], m_rd, m_wr}) begin
      failures++;
      $display("FAIL after_commit idle/ready/rdv/rdb/wrb got=%b%b%b%b%b exp=11%b%b%b", idle,
               bus.cmd_ready, bus.rd_valid, bus.rd_bank, bus.wr_bank, m_full[m_rd], m_rd, m_wr);
    end
`ifdef DBUF_LOAD_SCHED_PERF_EN
    eb = 32'(m_busy); el = 16'(m_loads);
`else
    eb = 32'd0; el = 16'd0;
`endif
    checks++;
    if ({perf_busy_cyc, perf_loads} !== {eb, el}) begin
      failures++;
      $display("FAIL perf busy=%0d loads=%0d exp %0d %0d", perf_busy_cyc, perf_loads, eb, el);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.ddr_req_ready = 1'b0; bus.ld_done = 1'b1; bus.rel_valid = 1'b0;
    bus.rel_bank = 1'b0; bus.cmd_mode = '0; bus.cmd_ch_num = '0; bus.cmd_row_num = '0;
    bus.cmd_pix_num = '0; bus.cmd_addr = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.cmd_ready, idle, bus.ld_start, bus.ddr_req_valid, bus.rd_valid, bus.rd_bank, bus.wr_bank,
         bus.ddr_req_addr, bus.ddr_req_len, bus.ld_mode, bus.ld_ch_num, perf_busy_cyc, perf_loads} !==
        {1'b1, 1'b1, 5'b0, 32'h0, 13'h0, 3'h0, 4'h0, 32'h0, 16'h0}) begin
      failures++;
      $display("FAIL reset_values ready=%b idle=%b start=%b req=%b rdv=%b rdb=%b wrb=%b addr=%h len=%0d",
               bus.cmd_ready, idle, bus.ld_start, bus.ddr_req_valid, bus.rd_valid, bus.rd_bank,
               bus.wr_bank, bus.ddr_req_addr, bus.ddr_req_len);
    end
  endtask

  task automatic test_fc_load();
    run_load(3'b001, 4'd7, 4'd0, 4'd0, 32'h1000, 0, 10, 0, 1'b0);
    checks++;
    if ({bus.rd_valid, bus.rd_bank, bus.wr_bank} !== 3'b101) begin
      failures++;
      $display("FAIL fc_commit rdv/rdb/wrb got=%b%b%b exp=101", bus.rd_valid, bus.rd_bank, bus.wr_bank);
    end
  endtask

  task automatic test_conv_len();
    run_load(3'b000, 4'd15, 4'd15, 4'd15, 32'h0004_0000, 1, 3, 0, 1'b0);
    checks++;
    if (bus.ddr_req_len !== 13'd4096) begin
      failures++;
      $display("FAIL conv_len got=%0d exp=4096", bus.ddr_req_len);
    end
  endtask

  task automatic test_alloc_stall();
    run_load(3'b110, 4'd2, 4'd1, 4'd3, $urandom, 0, 2, 0, 1'b0);
    checks++;
    if ({bus.rd_valid, bus.rd_bank, bus.wr_bank} !== 3'b111) begin
      failures++;
      $display("FAIL stall_resume rdv/rdb/wrb got=%b%b%b exp=111", bus.rd_valid, bus.rd_bank, bus.wr_bank);
    end
  endtask

  task automatic test_req_backpressure();
    do_release(1'b1);
    do_release(1'b0);
    run_load(3'b011, 4'd9, 4'd5, 4'd5, 32'hDEAD_BEE0, 5, 4, 0, 1'b0);
  endtask

  task automatic test_release_rules();
    do_reset();
    run_load(3'b000, 4'd1, 4'd1, 4'd1, 32'h2000, 0, 2, 0, 1'b0);
    do_release(1'b1);
    checks++;
    if ({bus.rd_valid, bus.rd_bank} !== 2'b10) begin
      failures++;
      $display("FAIL ooo_release rdv/rdb got=%b%b exp=10", bus.rd_valid, bus.rd_bank);
    end
    run_load(3'b001, 4'd3, 4'd0, 4'd0, 32'h3000, 1, 2, 0, 1'b1);
    checks++;
    if ({bus.rd_valid, bus.rd_bank, bus.wr_bank} !== 3'b110) begin
      failures++;
      $display("FAIL commit_with_release rdv/rdb/wrb got=%b%b%b exp=110", bus.rd_valid, bus.rd_bank, bus.wr_bank);
    end
    do_release(1'b0);
    do_release(1'b1);
  endtask

  task automatic test_stale_done();
    run_load(3'b001, 4'd5, 4'd0, 4'd0, 32'h5000, 2, 3, 3, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 12; k++) begin
      if ($urandom_range(0, 1) == 1) do_release(1'($urandom_range(0, 1)));
      run_load(3'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), $urandom,
               $urandom_range(0, 4), $urandom_range(1, 6), $urandom_range(0, 2),
               1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_midway();
    int n;
    if (m_full == 2'b00) run_load(3'b001, 4'd0, 4'd0, 4'd0, 32'h10, 0, 1, 0, 1'b0);
    if (m_full == 2'b11) do_release(m_rd);
    bus.cmd_valid = 1'b1; bus.cmd_mode = 3'b001; bus.cmd_ch_num = 4'd4; bus.cmd_addr = 32'h7000;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    n = 0;
    while (bus.ld_start !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin abort_run("midway_start"); return; end
    bus.ld_done = 1'b0;
    @(negedge clk);
    bus.ddr_req_ready = 1'b1;
    @(negedge clk);
    bus.ddr_req_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({idle, bus.rd_valid} !== 2'b01) begin
      failures++;
      $display("FAIL pre_reset idle/rdv got=%b%b exp=01", idle, bus.rd_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({idle, bus.cmd_ready, bus.rd_valid, bus.ld_start, bus.ddr_req_valid, bus.wr_bank, bus.rd_bank,
         perf_busy_cyc, perf_loads} !== {1'b1, 1'b1, 5'b0, 32'h0, 16'h0}) begin
      failures++;
      $display("FAIL async_reset idle=%b ready=%b rdv=%b start=%b req=%b wrb=%b rdb=%b busy=%0d loads=%0d",
               idle, bus.cmd_ready, bus.rd_valid, bus.ld_start, bus.ddr_req_valid, bus.wr_bank,
               bus.rd_bank, perf_busy_cyc, perf_loads);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.ld_done = 1'b1;
    model_reset();
    @(negedge clk);
    run_load(3'b000, 4'd3, 4'd2, 4'd1, 32'h8000, 1, 2, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_fc_load();
    test_conv_len();
    test_alloc_stall();
    test_req_backpressure();
    test_release_rules();
    test_stale_done();
    test_random();
    test_reset_midway();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
